rc4_key_search_ctrl: RTL
========================

Name: rc4_key_search_ctrl

Overview:
- Sequencer that drives one arcfour core through a brute-force key search.
- Presents each candidate key, pulses the core through a start/finished handshake, and samples a message-valid flag from the downstream plaintext checker.
- Stops on the first valid key, on key-space exhaustion, or on a peer abort.
- Sits between the top-level search FSM / multi-core partitioner and a single arcfour instance.

Parameters:
- KEY_W, 24: width of the key bus to arcfour.
- KEY_START, 0: first candidate key; set per core when partitioning.
- KEY_LAST, 24'h3FFFFF: highest legal candidate (inclusive).
- STRIDE, 1: key increment; equals the core count in multi-core builds.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- go  in  1  level; high starts the search, low returns a finished search to IDLE.
- abort  in  1  peer-found or user-cancel request.
- msg_valid  in  1  checker verdict for the current key; valid when arcfour_finished=1.
- arcfour_finished  in  1  core done flag; stays high until start_sig drops.
- start_sig  out  1  level start to arcfour.
- key  out  KEY_W  current candidate key to arcfour.
- busy  out  1  high in every state except IDLE and the DONE_* states.
- found  out  1  high in DONE_FOUND.
- exhausted  out  1  high in DONE_FAIL.
- aborted  out  1  high in DONE_ABORT.
- key_found  out  KEY_W  key that produced msg_valid.
- attempts  out  24  completed core runs; saturates at 24'hFFFFFF.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; start_sig=0; key=KEY_START; key_found=0; attempts=0; abort latch=0.
  - busy=found=exhausted=aborted=0.
  - Reset takes effect in any state, including mid-run; start_sig drops on the next edge.
- IDLE: on go=1 → START; key<=KEY_START; attempts<=0; abort latch<=0.
- START: start_sig<=1 → WAIT. There is one idle cycle between acceptance of go and the rising start_sig.
- WAIT:
  - start_sig is held at 1.
  - abort=1 sets the abort latch; the running core is never interrupted.
  - On arcfour_finished=1:
    - attempts increments, saturating.
    - msg_valid=1 → key_found<=key → DONE_FOUND. A valid key wins over a simultaneous abort or last-key condition.
    - Else, abort latch or abort=1 → DONE_ABORT.
    - Else, last key → DONE_FAIL.
    - Else → RELEASE.
- Last-key test: compute key+STRIDE in KEY_W+1 bits. It is the last key if the sum is greater than KEY_LAST or carries out.
- RELEASE:
  - start_sig<=0.
  - Stay until arcfour_finished=0.
  - Then key<=key+STRIDE (truncated to KEY_W) → START, or → DONE_ABORT if the abort latch is set.
  - Minimum cycles between start_sig runs: 2.
- DONE_FOUND / DONE_FAIL / DONE_ABORT:
  - start_sig=0.
  - Status outputs, key_found, and attempts are held.
  - go=0 → IDLE.
  - abort is ignored in these states.
- go dropping while busy has no effect; the search runs to a DONE_* state.
- key changes only in IDLE or RELEASE, so it is stable for the entire time start_sig is high.
- Exactly one of found / exhausted / aborted is high, and only in its DONE_* state.
- All outputs are registered.

Test Plan:
- Bench uses KEY_START=0, KEY_LAST=5, STRIDE=1, and a stub core that raises finished 4 cycles after start_sig and drops it 1 cycle after start_sig falls.
- Valid key: msg_valid=1 only when key=3 → found=1, key_found=3, attempts=4; keys 0,1,2,3 each presented once with start_sig high.
- Exhaustion: msg_valid never asserted → exhausted=1 after key=5, attempts=6, key never exceeds 5. Then go=0 → IDLE with busy=0.
- Stride/overflow: KEY_W=4, KEY_START=13, KEY_LAST=15, STRIDE=2 → keys 13, 15, then DONE_FAIL; the 15+2 overflow does not wrap to 1.
- Abort: abort pulsed for 1 cycle while key=1 is in WAIT → run completes; aborted=1; attempts=2; key stays 1. Variant with msg_valid=1 on that same key → found=1, aborted=0.
- Reset mid-run: reset=0 in WAIT with key=2 → next edge shows start_sig=0, key=0, attempts=0, busy=0. Release reset with go=1 → search restarts at key 0.

Source files
------------

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force key search sequencer for a single arcfour core: steps candidate
// keys, handshakes each run, and stops on a valid key, exhaustion or abort.
module rc4_key_search_ctrl #(
    parameter int unsigned          KEY_W     = 24,
    parameter logic [KEY_W-1:0]     KEY_START = '0,
    parameter logic [KEY_W-1:0]     KEY_LAST  = KEY_W'(24'h3FFFFF),
    parameter int unsigned          STRIDE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             abort,
    input  logic             msg_valid,
    input  logic             arcfour_finished,
    output logic             start_sig,
    output logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic             aborted,
    output logic [KEY_W-1:0] key_found,
    output logic [23:0]      attempts
);

    localparam int unsigned  ATT_W    = 24;
    localparam logic [ATT_W-1:0] ATT_MAX = {ATT_W{1'b1}};
    localparam logic [KEY_W:0]   STRIDE_X = (KEY_W+1)'(STRIDE);
    localparam logic [KEY_W:0]   LAST_X   = {1'b0, KEY_LAST};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RELEASE,
        S_FOUND,
        S_FAIL,
        S_ABORT
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [KEY_W-1:0]   key_found_q, key_found_d;
    logic [ATT_W-1:0]   attempts_q, attempts_d;
    logic               abort_q, abort_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic               aborted_q, aborted_d;

    logic [KEY_W:0]     key_sum;
    logic               is_last;

    // Sum is widened by one bit so a carry out also counts as past the end.
    assign key_sum = {1'b0, key_q} + STRIDE_X;
    assign is_last = key_sum[KEY_W] || (key_sum > LAST_X);

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_found_d = key_found_q;
        attempts_d  = attempts_q;
        abort_d     = abort_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d    = S_START;
                    key_d      = KEY_START;
                    attempts_d = '0;
                    abort_d    = 1'b0;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (arcfour_finished) begin
                    if (attempts_q != ATT_MAX) begin
                        attempts_d = attempts_q + ATT_W'(1);
                    end
                    if (msg_valid) begin
                        key_found_d = key_q;
                        state_d     = S_FOUND;
                    end else if (abort_q || abort) begin
                        state_d = S_ABORT;
                    end else if (is_last) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (!arcfour_finished) begin
                    if (abort_q) begin
                        state_d = S_ABORT;
                    end else begin
                        key_d   = key_sum[KEY_W-1:0];
                        state_d = S_START;
                    end
                end
            end
            S_FOUND, S_FAIL, S_ABORT: begin
                if (!go) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are decoded from the next state so they register in step.
        start_d     = (state_d == S_WAIT);
        busy_d      = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_RELEASE);
        found_d     = (state_d == S_FOUND);
        exhausted_d = (state_d == S_FAIL);
        aborted_d   = (state_d == S_ABORT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            key_q       <= KEY_START;
            key_found_q <= '0;
            attempts_q  <= '0;
            abort_q     <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_found_q <= key_found_d;
            attempts_q  <= attempts_d;
            abort_q     <= abort_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            found_q     <= found_d;
            exhausted_q <= exhausted_d;
            aborted_q   <= aborted_d;
        end
    end

    assign start_sig = start_q;
    assign key       = key_q;
    assign busy      = busy_q;
    assign found     = found_q;
    assign exhausted = exhausted_q;
    assign aborted   = aborted_q;
    assign key_found = key_found_q;
    assign attempts  = attempts_q;

endmodule
